// File: rtl/fp_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_packer
// Description : Round-to-nearest-even, special/overflow/underflow resolution
//               and IEEE-754 packing, with a 2-entry valid/ready result buffer.
//               Optional macro FP_PACK_FLAGS_EN enables ovf/unf/inx flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_packer #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     en,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     sR,
   input  logic [EXP_W+1:0]         exp_in,
   input  logic [MAN_W+3:0]         man_in,
   input  logic                     zero_in,
   input  logic                     inf_in,
   input  logic                     nan_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic                     ovf_o,
   output logic                     unf_o,
   output logic                     inx_o
);

   localparam int c_RES_W = EXP_W + MAN_W + 1;
   localparam int c_EW    = EXP_W + 3;
   localparam logic signed [c_EW-1:0] c_EXP_MAX = c_EW'((1 << EXP_W) - 1);

   logic                     w_pop, w_push, w_s2_adv, w_s1_en, w_s2_en;
   logic                     w_inc, w_carry;
   logic [MAN_W+1:0]         w_sum;
   logic [MAN_W-1:0]         w_frac;
   logic signed [c_EW-1:0]   w_exp_rnd;
   logic                     w_exp_hi, w_exp_lo;
   logic [c_RES_W-1:0]       w_res;

   logic                     r_s1_valid, r_s1_sign, r_s1_zero, r_s1_inf, r_s1_nan;
   logic signed [c_EW-1:0]   r_s1_exp;
   logic [MAN_W-1:0]         r_s1_frac;
   logic                     r_s2_valid;
   logic [c_RES_W-1:0]       r_s2_res;
   logic [c_RES_W-1:0]       r_mem_res [2];
   logic [1:0]               r_count;
   logic                     r_wr, r_rd;

   // Handshake: the buffer pops regardless of en; stages only move when en is high.
   assign w_pop    = (r_count != 2'd0) & out_ready;
   assign w_s2_adv = (r_count != 2'd2) | w_pop;
   assign w_s2_en  = en & (~r_s2_valid | w_s2_adv);
   assign w_s1_en  = en & (~r_s1_valid | ~r_s2_valid | w_s2_adv);
   assign w_push   = w_s2_en & r_s2_valid;
   assign in_ready = w_s1_en & ~arst;

   // Round to nearest even on {hidden, fraction}; a carry out renormalises by one.
   assign w_inc     = man_in[2] & (man_in[1] | man_in[0] | man_in[3]);
   assign w_sum     = {1'b0, man_in[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, w_inc};
   assign w_carry   = w_sum[MAN_W+1];
   assign w_frac    = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
   assign w_exp_rnd = $signed({exp_in[EXP_W+1], exp_in}) + $signed({{(c_EW-1){1'b0}}, w_carry});

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_exp   <= '0;
         r_s1_frac  <= '0;
         r_s1_zero  <= 1'b0;
         r_s1_inf   <= 1'b0;
         r_s1_nan   <= 1'b0;
      end else if (w_s1_en) begin
         r_s1_valid <= in_valid;
         r_s1_sign  <= sR;
         r_s1_exp   <= w_exp_rnd;
         r_s1_frac  <= w_frac;
         r_s1_zero  <= zero_in;
         r_s1_inf   <= inf_in;
         r_s1_nan   <= nan_in;
      end
   end

   assign w_exp_hi = (r_s1_exp >= c_EXP_MAX);
   assign w_exp_lo = (r_s1_exp <= $signed({c_EW{1'b0}}));

   always_comb begin
      w_res = {r_s1_sign, r_s1_exp[EXP_W-1:0], r_s1_frac};
      if (r_s1_nan)
         w_res = {r_s1_sign, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (r_s1_inf)
         w_res = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (r_s1_zero)
         w_res = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
      else if (w_exp_hi)
         w_res = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (w_exp_lo)
         w_res = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_s2_valid <= 1'b0;
         r_s2_res   <= '0;
      end else if (w_s2_en) begin
         r_s2_valid <= r_s1_valid;
         r_s2_res   <= w_res;
      end
   end

   // Two-slot ring; a push into a full buffer lands in the slot being popped.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_mem_res[0] <= '0;
         r_mem_res[1] <= '0;
         r_count      <= 2'd0;
         r_wr         <= 1'b0;
         r_rd         <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem_res[r_wr] <= r_s2_res;
            r_wr            <= ~r_wr;
         end
         if (w_pop)
            r_rd <= ~r_rd;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_valid = (r_count != 2'd0);
   assign result    = out_valid ? r_mem_res[r_rd] : '0;

`ifdef FP_PACK_FLAGS_EN
   logic       w_special, w_ovf, w_unf, w_inx;
   logic       r_s1_inx;
   logic [2:0] r_s2_flg;
   logic [2:0] r_mem_flg [2];

   assign w_special = r_s1_nan | r_s1_inf | r_s1_zero;
   assign w_ovf     = ~w_special & w_exp_hi;
   assign w_unf     = ~w_special & ~w_exp_hi & w_exp_lo;
   assign w_inx     = ~w_special & (w_ovf | w_unf | r_s1_inx);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_s1_inx     <= 1'b0;
         r_s2_flg     <= 3'b000;
         r_mem_flg[0] <= 3'b000;
         r_mem_flg[1] <= 3'b000;
      end else begin
         if (w_s1_en)
            r_s1_inx <= |man_in[2:0];
         if (w_s2_en)
            r_s2_flg <= {w_ovf, w_unf, w_inx};
         if (w_push)
            r_mem_flg[r_wr] <= r_s2_flg;
      end
   end

   assign {ovf_o, unf_o, inx_o} = out_valid ? r_mem_flg[r_rd] : 3'b000;
`else
   assign ovf_o = 1'b0;
   assign unf_o = 1'b0;
   assign inx_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_result_packer
// Description : Self-checking bench for fp_result_packer (binary32), with an
//               arithmetic reference model and scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_result_packer;

   logic        clk, arst, en, in_valid, in_ready, sR, zero_in, inf_in, nan_in;
   logic        out_valid, out_ready, ovf_o, unf_o, inx_o;
   logic [9:0]  exp_in;
   logic [26:0] man_in;
   logic [31:0] result;

   int          n_cmp, n_bad, acc_cnt, pop_cnt;
   logic [34:0] exp_q[$];
   logic [34:0] got_q[$];

   fp_result_packer #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .arst(arst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .sR(sR), .exp_in(exp_in), .man_in(man_in), .zero_in(zero_in), .inf_in(inf_in),
      .nan_in(nan_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .ovf_o(ovf_o), .unf_o(unf_o), .inx_o(inx_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Value-level model: round the 24-bit significand by its 3-bit remainder.
   function automatic logic [34:0] ref_pack(input logic s, input logic [9:0] e,
                                            input logic [26:0] m, input logic z,
                                            input logic i, input logic n);
      int ee, rem;
      longint mv;
      logic [31:0] r;
      logic ov, un, ix;
      ee = $signed(e);
      mv = longint'(m >> 3);
      rem = int'(m[2:0]);
      ov = 1'b0; un = 1'b0; ix = 1'b0;
      if (n)      r = {s, 8'hFF, 23'h400000};
      else if (i) r = {s, 8'hFF, 23'h0};
      else if (z) r = {s, 31'h0};
      else begin
         ix = (rem != 0);
         if (rem > 4 || (rem == 4 && mv % 2 == 1)) mv = mv + 1;
         if (mv >= 64'd16777216) begin mv = mv / 2; ee = ee + 1; end
         if (ee >= 255)    begin r = {s, 8'hFF, 23'h0}; ov = 1'b1; ix = 1'b1; end
         else if (ee <= 0) begin r = {s, 31'h0}; un = 1'b1; ix = 1'b1; end
         else r = {s, 8'(ee), 23'(mv)};
      end
`ifndef FP_PACK_FLAGS_EN
      ov = 1'b0; un = 1'b0; ix = 1'b0;
`endif
      return {r, ov, un, ix};
   endfunction

   // Scoreboard capture, sampled mid-cycle while inputs and outputs are stable.
   always @(negedge clk) begin
      if (!arst) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_pack(sR, exp_in, man_in, zero_in, inf_in, nan_in));
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            got_q.push_back({result, ovf_o, unf_o, inx_o});
            pop_cnt++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic s, input logic [9:0] e, input logic [26:0] m,
                           input logic z, input logic i, input logic n);
      sR = s; exp_in = e; man_in = m; zero_in = z; inf_in = i; nan_in = n;
   endtask

   task automatic rand_beat(input bit allow_special);
      int k;
      k = allow_special ? int'($urandom_range(0, 15)) : 15;
      set_beat(1'($urandom), 10'(int'($urandom_range(0, 300)) - 20), {1'b1, 26'($urandom)},
               1'b0, 1'b0, 1'b0);
      case (k)
         0: begin nan_in = 1'b1; inf_in = 1'($urandom); zero_in = 1'($urandom); end
         1: begin inf_in = 1'b1; zero_in = 1'($urandom); end
         2: begin zero_in = 1'b1; man_in = 27'($urandom); end
         3: exp_in = 10'($urandom_range(252, 256));
         4: exp_in = 10'(int'($urandom_range(0, 2)) - 1);
         5: man_in = {1'b1, 23'h7FFFFF, 3'($urandom)};
         default: ;
      endcase
   endtask

   task automatic drain;
      in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
      repeat (3) tick();
   endtask

   task automatic test_reset;
      arst = 1'b1; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      rand_beat(1'b0);
      repeat (2) tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
      n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h need 0", result); end
      n_cmp++; if ({ovf_o, unf_o, inx_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b need 000", {ovf_o, unf_o, inx_o}); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
      in_valid = 1'b0;
      arst = 1'b0;
      tick();
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_directed;
      logic [31:0] dres [7];
      logic [2:0]  dflg [7];
      dres = '{32'h3F800000, 32'h40000000, 32'h7F800000, 32'hFF800000,
               32'h80000000, 32'h7FC00000, 32'h80000000};
`ifdef FP_PACK_FLAGS_EN
      dflg = '{3'b000, 3'b001, 3'b101, 3'b101, 3'b011, 3'b000, 3'b011};
`else
      dflg = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
      en = 1'b1; out_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         case (v)
            0: set_beat(1'b0, 10'd127, 27'h4000000, 1'b0, 1'b0, 1'b0);
            1: set_beat(1'b0, 10'd127, 27'h7FFFFFC, 1'b0, 1'b0, 1'b0);
            2: set_beat(1'b0, 10'd255, 27'h4000000, 1'b0, 1'b0, 1'b0);
            3: set_beat(1'b1, 10'd255, 27'h4000000, 1'b0, 1'b0, 1'b0);
            4: set_beat(1'b1, 10'd0,   27'h4000000, 1'b0, 1'b0, 1'b0);
            5: set_beat(1'b0, 10'd127, 27'h0,       1'b1, 1'b0, 1'b1);
            default: set_beat(1'b1, 10'h3F6, 27'h5555555, 1'b0, 1'b0, 1'b0);
         endcase
         in_valid = 1'b1;
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d_in_ready: got %b need 1", v, in_ready); end
         tick();
         in_valid = 1'b0;
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_lat1: out_valid got %b need 0", v, out_valid); end
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_lat2: out_valid got %b need 0", v, out_valid); end
         tick();
         n_cmp++;
         if ({out_valid, result, ovf_o, unf_o, inx_o} !== {1'b1, dres[v], dflg[v]}) begin
            n_bad++;
            $display("FAIL dir%0d_result: got v=%b %h flags=%b need v=1 %h flags=%b",
                     v, out_valid, result, {ovf_o, unf_o, inx_o}, dres[v], dflg[v]);
         end
      end
      drain();
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_random;
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         rand_beat(1'b1);
         tick();
      end
      drain();
      n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         n_cmp++;
         if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL rand_beat%0d: got %h need %h", j, got_q[j], exp_q[j]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back;
      int a0;
      logic [34:0] held;
      a0 = acc_cnt;
      en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin rand_beat(1'b0); tick(); end
      n_cmp++; if (acc_cnt - a0 !== 4) begin n_bad++; $display("FAIL bp_accepted: got %0d need 4", acc_cnt - a0); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b need 0", in_ready); end
      held = {result, ovf_o, unf_o, inx_o};
      tick();
      n_cmp++; if ({result, ovf_o, unf_o, inx_o} !== held || out_valid !== 1'b1) begin
         n_bad++; $display("FAIL bp_hold: got v=%b %h need v=1 %h", out_valid, {result, ovf_o, unf_o, inx_o}, held);
      end
      drain();
      n_cmp++; if (got_q.size() !== 4 || exp_q.size() !== 4) begin n_bad++; $display("FAIL bp_count: got %0d/%0d beats need 4/4", got_q.size(), exp_q.size()); end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         n_cmp++;
         if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL bp_beat%0d: got %h need %h", j, got_q[j], exp_q[j]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_arst;
      en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin rand_beat(1'b1); tick(); end
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre: out_valid got %b need 1", out_valid); end
      arst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || result !== 32'h0) begin n_bad++; $display("FAIL arst_now: got v=%b %h need v=0 0", out_valid, result); end
      exp_q.delete(); got_q.delete();
      tick();
      arst = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_idle%0d: out_valid got %b need 0", c, out_valid); end
      end
      rand_beat(1'b0);
      in_valid = 1'b1;
      tick();
      drain();
      n_cmp++; if (got_q.size() !== 1 || exp_q.size() !== 1) begin n_bad++; $display("FAIL arst_count: got %0d/%0d beats need 1/1", got_q.size(), exp_q.size()); end
      else begin
         n_cmp++; if (got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL arst_beat: got %h need %h", got_q[0], exp_q[0]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_en_stall;
      int a0, p0;
      en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin rand_beat(1'b0); tick(); end
      en = 1'b0;
      a0 = acc_cnt; p0 = pop_cnt;
      for (int c = 0; c < 5; c++) begin
         rand_beat(1'b0);
         tick();
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready%0d: got %b need 0", c, in_ready); end
      end
      n_cmp++; if (acc_cnt !== a0) begin n_bad++; $display("FAIL stall_accepts: got %0d need %0d", acc_cnt, a0); end
      n_cmp++; if (pop_cnt - p0 !== 1) begin n_bad++; $display("FAIL stall_pops: got %0d need 1", pop_cnt - p0); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_frozen: out_valid got %b need 0", out_valid); end
      drain();
      n_cmp++; if (got_q.size() !== 3 || exp_q.size() !== 3) begin n_bad++; $display("FAIL stall_count: got %0d/%0d beats need 3/3", got_q.size(), exp_q.size()); end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         n_cmp++;
         if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL stall_beat%0d: got %h need %h", j, got_q[j], exp_q[j]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_bad = 0; acc_cnt = 0; pop_cnt = 0;
      arst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_beat(1'b0, 10'd0, 27'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_arst();
      test_en_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
